// File: rtl/note_sequencer.sv
// Beat-tick sequencer for the 4-lane note datapath: pattern-RAM addressing, shifter load/shift, key judging.
// state | meaning: IDLE wait start | PRELOAD first load | PLAY | PAUSED | DRAIN flush shifters | DONE song over
module note_sequencer #(
  parameter int TICK_DIV       = 12500000,
  parameter int BEATS_PER_WORD = 4,
  parameter int SONG_LENGTH    = 128,
  parameter int ADDR_W         = 7,
  parameter int DRAIN_TICKS    = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic [3:0]        key_hit,
  input  logic [3:0]        lane_now,
  output logic [ADDR_W-1:0] ram_address,
  output logic              load_en,
  output logic              shift_en,
  output logic              score_inc,
  output logic              miss_pulse,
  output logic              song_done,
  output logic [2:0]        state
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W  = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam int DR_W  = $clog2(DRAIN_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_TC     = PH_W'(BEATS_PER_WORD - 1);
  localparam logic [DR_W-1:0]   DR_TC     = DR_W'(DRAIN_TICKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSED  = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             st, st_nxt, resume;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [PH_W-1:0]    phase, phase_nxt;
  logic [DR_W-1:0]    drain_cnt, drain_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               ret_drain, ret_nxt;
  logic               hit_flag, hit_nxt, wrong_flag, wrong_nxt;
  logic               score_nxt, miss_nxt;
  logic               active, tick;
  logic               hit_now, wrong_now, hit_win, wrong_win;

  assign active    = (st == S_PLAY) || (st == S_DRAIN);
  assign tick      = active && (div == DIV_TC);
  assign shift_en  = tick;
  assign load_en   = (st == S_PRELOAD) || ((st == S_PLAY) && tick && (phase == PH_TC));
  assign song_done = (st == S_DONE);
  assign state     = st;

  always_comb begin
    st_nxt    = st;
    resume    = st;
    div_nxt   = div;
    phase_nxt = phase;
    drain_nxt = drain_cnt;
    addr_nxt  = ram_address;
    ret_nxt   = ret_drain;
    hit_nxt   = hit_flag;
    wrong_nxt = wrong_flag;
    score_nxt = 1'b0;
    miss_nxt  = 1'b0;

    hit_now   = (lane_now != 4'd0) && (key_hit == lane_now);
    wrong_now = (key_hit & ~lane_now) != 4'd0;
    hit_win   = hit_flag | hit_now;
    wrong_win = wrong_flag | wrong_now;

    if (active) begin
      div_nxt   = tick ? '0 : div + 1'b1;
      hit_nxt   = hit_win;
      wrong_nxt = wrong_win;
      if (tick) begin
        // the tick cycle's own key state still belongs to the closing window
        phase_nxt = (phase == PH_TC) ? '0 : phase + 1'b1;
        score_nxt = hit_win & ~wrong_win;
        miss_nxt  = ~(hit_win & ~wrong_win) & ((lane_now != 4'd0) | wrong_win);
        hit_nxt   = 1'b0;
        wrong_nxt = 1'b0;
      end
    end

    case (st)
      S_IDLE, S_DONE: begin
        if (start) begin
          st_nxt    = S_PRELOAD;
          div_nxt   = '0;
          phase_nxt = '0;
          drain_nxt = '0;
          addr_nxt  = '0;
          hit_nxt   = 1'b0;
          wrong_nxt = 1'b0;
        end
      end
      S_PRELOAD: begin
        if (SONG_LENGTH == 1) begin
          st_nxt = S_DRAIN;
        end else begin
          st_nxt   = S_PLAY;
          addr_nxt = ram_address + 1'b1;
        end
      end
      S_PLAY, S_DRAIN: begin
        if (st == S_PLAY && load_en) begin
          if (ram_address == LAST_ADDR) resume = S_DRAIN;
          else addr_nxt = ram_address + 1'b1;
        end
        if (st == S_DRAIN && tick) begin
          if (drain_cnt == DR_TC) resume = S_DONE;
          else drain_nxt = drain_cnt + 1'b1;
        end
        if (pause && resume != S_DONE) begin
          st_nxt  = S_PAUSED;
          ret_nxt = (resume == S_DRAIN);
        end else begin
          st_nxt = resume;
        end
      end
      S_PAUSED: begin
        if (!pause) st_nxt = ret_drain ? S_DRAIN : S_PLAY;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      div         <= '0;
      phase       <= '0;
      drain_cnt   <= '0;
      ram_address <= '0;
      ret_drain   <= 1'b0;
      hit_flag    <= 1'b0;
      wrong_flag  <= 1'b0;
      score_inc   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      st          <= st_nxt;
      div         <= div_nxt;
      phase       <= phase_nxt;
      drain_cnt   <= drain_nxt;
      ram_address <= addr_nxt;
      ret_drain   <= ret_nxt;
      hit_flag    <= hit_nxt;
      wrong_flag  <= wrong_nxt;
      score_inc   <= score_nxt;
      miss_pulse  <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed song steps with random key/lane traffic against a beat-count model.
module tb_note_sequencer;
  localparam int TD  = 4;
  localparam int BPW = 4;
  localparam int SL  = 4;
  localparam int AW  = 7;
  localparam int DT  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [3:0]    key_hit = 4'd0;
  logic [3:0]    lane_now = 4'd0;
  logic [AW-1:0] ram_address;
  logic          load_en, shift_en, score_inc, miss_pulse, song_done;
  logic [2:0]    state;

  int checks = 0;
  int passed = 0;

  // model: mode 0..5, active cycles since preload, loads issued, drain ticks seen
  int m_mode, m_act, m_loads, m_drain;
  bit m_ret_drain, m_hit, m_wrong, m_score, m_miss;
  logic obs_score, obs_miss;

  note_sequencer #(
    .TICK_DIV(TD), .BEATS_PER_WORD(BPW), .SONG_LENGTH(SL), .ADDR_W(AW), .DRAIN_TICKS(DT)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start), .pause(pause),
    .key_hit(key_hit), .lane_now(lane_now), .ram_address(ram_address),
    .load_en(load_en), .shift_en(shift_en), .score_inc(score_inc),
    .miss_pulse(miss_pulse), .song_done(song_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_mode = 0; m_act = 0; m_loads = 0; m_drain = 0;
    m_ret_drain = 0; m_hit = 0; m_wrong = 0; m_score = 0; m_miss = 0;
  endtask

  // one clock: compare at the falling edge, then advance the model across the rising edge
  task automatic cycle();
    bit act, tick, ld, h, w;
    int tno, tgt, nmode;
    @(negedge clk);
    act  = (m_mode == 2 || m_mode == 4);
    tick = act && (m_act % TD == TD - 1);
    tno  = m_act / TD + 1;
    ld   = (m_mode == 1) || (m_mode == 2 && tick && (tno % BPW == 0));
    check("state", 32'(state), m_mode);
    check("ram_address", 32'(ram_address), (m_loads < SL - 1) ? m_loads : SL - 1);
    check("shift_en", 32'(shift_en), 32'(tick));
    check("load_en", 32'(load_en), 32'(ld));
    check("score_inc", 32'(score_inc), 32'(m_score));
    check("miss_pulse", 32'(miss_pulse), 32'(m_miss));
    check("song_done", 32'(song_done), 32'(m_mode == 5));
    obs_score = score_inc;
    obs_miss  = miss_pulse;

    m_score = 0; m_miss = 0;
    h = m_hit; w = m_wrong;
    if (act) begin
      h = h || (lane_now != 4'd0 && key_hit == lane_now);
      w = w || ((key_hit & ~lane_now) != 4'd0);
      if (tick) begin
        m_score = h && !w;
        m_miss  = !(h && !w) && (lane_now != 4'd0 || w);
        h = 0; w = 0;
      end
    end
    nmode = m_mode;
    case (m_mode)
      0, 5: if (start) begin
        nmode = 1; m_act = 0; m_loads = 0; m_drain = 0; h = 0; w = 0;
      end
      1: begin m_loads++; nmode = 2; end
      2, 4: begin
        tgt = m_mode;
        m_act++;
        if (m_mode == 2 && ld) begin
          if (m_loads == SL - 1) tgt = 4;
          m_loads++;
        end
        if (m_mode == 4 && tick) begin
          m_drain++;
          if (m_drain == DT) tgt = 5;
        end
        if (pause && tgt != 5) begin nmode = 3; m_ret_drain = (tgt == 4); end
        else nmode = tgt;
      end
      3: if (!pause) nmode = m_ret_drain ? 4 : 2;
      default: nmode = 0;
    endcase
    m_hit = h; m_wrong = w;
    @(posedge clk);
    #1;
    m_mode = nmode;
  endtask

  task automatic rand_inputs(input bit with_pause);
    int r;
    lane_now = 4'($urandom_range(0, 15));
    r = $urandom_range(0, 3);
    key_hit = (r == 1) ? lane_now : (r == 2) ? 4'($urandom_range(0, 15)) : 4'd0;
    pause = with_pause && ($urandom_range(0, 7) == 0);
  endtask

  // one full judge window: align to a fresh window, key k1 in cycle 1, k2 in cycle 2
  task automatic window(input string tag, input logic [3:0] lane, input logic [3:0] k1,
                        input logic [3:0] k2, input bit es, input bit em);
    int n;
    lane_now = 4'd0; key_hit = 4'd0; pause = 1'b0;
    n = 0;
    while (!((m_mode == 2 || m_mode == 4) && m_act % TD == 0) && n < 3 * TD) begin
      cycle(); n++;
    end
    if (n >= 3 * TD) check({tag, "_align"}, 32'(m_mode), 2);
    for (int i = 0; i < TD; i++) begin
      lane_now = lane;
      key_hit = (i == 1) ? k1 : (i == 2) ? k2 : 4'd0;
      cycle();
    end
    lane_now = 4'd0; key_hit = 4'd0;
    cycle();
    check({tag, "_score"}, 32'(obs_score), 32'(es));
    check({tag, "_miss"}, 32'(obs_miss), 32'(em));
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_addr", 32'(ram_address), 0);
    check("rst_pulses", {28'd0, load_en, shift_en, score_inc, miss_pulse}, 0);
    check("rst_done", 32'(song_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // start: IDLE -> PRELOAD -> PLAY, beat ticks and first word loads
    cycle();
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // pause with divider at 2
    n = 0;
    while (!(m_mode == 2 && m_act % TD == 1) && n < 2 * TD) begin cycle(); n++; end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("paused_state", 32'(state), 3);
    pause = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    window("hit", 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0);
    window("hit_wrong", 4'b0101, 4'b0101, 4'b0111, 1'b0, 1'b1);
    window("no_key", 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b1);
    window("empty", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    window("stray_key", 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b1);

    // finish the song under random traffic
    n = 0;
    while (m_mode != 5 && n < 400) begin rand_inputs(1'b1); cycle(); n++; end
    if (n >= 400) check("song_end_timeout", 32'(m_mode), 5);
    for (int i = 0; i < 6; i++) begin rand_inputs(1'b1); cycle(); end
    check("done_flag", 32'(song_done), 1);

    // restart from DONE and play with random pauses until mid-drain
    pause = 1'b0; start = 1'b1; cycle(); start = 1'b0;
    n = 0;
    while (!(m_mode == 4 && m_drain >= 3) && n < 600) begin rand_inputs(1'b1); cycle(); n++; end
    if (n >= 600) check("drain_timeout", 32'(m_mode), 4);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_addr", 32'(ram_address), 0);
    check("async_pulses", {28'd0, load_en, shift_en, score_inc, miss_pulse}, 0);
    check("async_done", 32'(song_done), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pause = 1'b0; key_hit = 4'd0; lane_now = 4'd0;
    for (int i = 0; i < 3; i++) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_inputs(1'b0); cycle(); end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Game controller for the 4-lane note datapath. It divides CLOCK_50 into beat ticks and drives the shared pattern-RAM address. It issues load and shift enables to the per-lane shifter chains and judges player key presses against the notes leaving the chains, producing score and miss strobes for the score keeper. It also owns the song lifecycle: idle, preload, play, pause, drain and done.

Parameters:
TICK_DIV, 12500000, CLOCK_50 cycles per beat tick (4 Hz); must be >= 2
BEATS_PER_WORD, 4, ticks per RAM word (shifter load stage depth)
SONG_LENGTH, 128, number of RAM words in a song; must be <= 2^ADDR_W
ADDR_W, 7, pattern RAM address width
DRAIN_TICKS, 8, ticks after the last load before the song is done (total shifter depth)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; begins a song from IDLE, restarts from DONE
pause  in  1  level; while high, PLAY/DRAIN freeze
key_hit  in  4  lane key pressed, active-high (lane 0 = bit 0)
lane_now  in  4  bit [0] of each lane's bottom shifter (note at strike line)
ram_address  out  ADDR_W  shared pattern RAM read address
load_en  out  1  one-cycle pulse: shifters capture RAM q
shift_en  out  1  one-cycle pulse: shifters advance one stage
score_inc  out  1  one-cycle pulse: note hit
miss_pulse  out  1  one-cycle pulse: note missed or wrong key
song_done  out  1  high in DONE
state  out  3  IDLE=0 PRELOAD=1 PLAY=2 PAUSED=3 DRAIN=4 DONE=5

Behaviour:
- Reset (async, reset_n=0): state IDLE; ram_address, divider, phase, drain count, hit/wrong flags = 0; all pulse outputs 0; song_done 0.
- Divider counts 0..TICK_DIV-1 only in PLAY/DRAIN. tick = one cycle at the terminal count. Divider holds its value in PAUSED. It clears on entering PRELOAD.
- shift_en = tick.
- Phase counter (0..BEATS_PER_WORD-1) advances on tick and wraps.
- PLAY: load_en = tick AND phase==BEATS_PER_WORD-1; it coincides with shift_en. ram_address increments on the cycle after load_en. RAM q must therefore be valid for >= 1 cycle before the next load, which TICK_DIV>=2 guarantees.
- IDLE: ram_address=0. start=1 -> PRELOAD.
- PRELOAD: exactly one cycle. load_en=1 and shift_en=0. ram_address becomes 1. Next state PLAY.
- PLAY: on a load issued with ram_address==SONG_LENGTH-1, go to DRAIN and hold ram_address (no wrap). pause=1 -> PAUSED.
- PAUSED: no ticks. pause=0 -> return to the saved state (PLAY or DRAIN); store a 1-bit return flag.
- DRAIN: shift_en continues, load_en=0. Drain counter counts ticks. When the DRAIN_TICKS-th tick occurs -> DONE. pause handled as in PLAY.
- DONE: song_done=1, no pulses. start=1 -> PRELOAD with ram_address reset to 0 before the preload load, giving a full restart.
- start is ignored outside IDLE/DONE. pause is ignored in IDLE/PRELOAD/DONE.
- Judge window (PLAY/DRAIN, not PAUSED):
  - hit flag sets in any cycle where lane_now!=0 and key_hit==lane_now.
  - wrong flag sets in any cycle where key_hit has a bit outside lane_now.
  - On tick, evaluate with the pre-tick lane_now:
    - score_inc=1 if hit & ~wrong.
    - else miss_pulse=1 if lane_now!=0 or wrong.
  - Both flags clear on the same tick, so the next window starts clean. The flag setting in the tick cycle itself counts toward the closing window.
- Empty window (lane_now==0, no keys): no pulse.
- score_inc and miss_pulse are never high together.
- Flags hold during PAUSED; key_hit is ignored while paused.
- All outputs are registered except shift_en/load_en, which may be combinational from the registered tick/phase.

Test Plan:
Use TICK_DIV=4, SONG_LENGTH=4, BEATS_PER_WORD=4, DRAIN_TICKS=8 for all scenarios.
1. Reset then start=1 for 1 cycle -> state 0->1->2; load_en at PRELOAD cycle, ram_address=1; shift_en every 4 cycles; next load_en on the 4th tick, ram_address=2 the cycle after.
2. Full song -> loads at addresses 0,1,2,3; after load at address 3, state=4, ram_address stays 3; exactly 8 further shift_en; then state=5, song_done=1, no more pulses.
3. pause=1 for 10 cycles mid-PLAY with divider at 2 -> state=3, no shift_en/load_en; divider resumes at 2 on release; next tick 2 cycles after returning to PLAY.
4. lane_now=0101, key_hit=0101 for 1 cycle inside a window -> score_inc on the tick; key_hit=0111 in the same window -> miss_pulse instead; key_hit=0 throughout -> miss_pulse.
5. lane_now=0, key_hit=0 -> no pulse. lane_now=0, key_hit=1000 -> miss_pulse on the tick.
6. reset_n low mid-DRAIN (async, between clocks) -> all outputs 0 and state=0 immediately. DONE + start -> PRELOAD with load at ram_address 0.
